// File: rtl/gb_waveram.sv
// gb_waveram: Channel 3 wave pattern RAM (16 bytes / 32 four-bit samples).
// Serves CPU reads and writes in the 0xFF3X window and feeds the wave channel
// through a registered sample buffer. While the channel is on, CPU accesses
// are redirected to the byte currently being played.
// Optional build macro: GB_WAVE_DMG_QUIRK_EN -- DMG-style access window where
// CPU access is only honoured for ACCESS_WINDOW cycles after a channel fetch.
module gb_waveram #(
    parameter int ACCESS_WINDOW = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cpu_addr,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic [7:0] cpu_wdata,
    output logic [7:0] cpu_rdata,
    input  logic       ch_on,
    input  logic [3:0] ch_addr,
    output logic [7:0] ch_data
);

    logic [7:0]  mem [16];
    logic [3:0]  prev_addr;
    logic        prev_on;
    logic        fetch;
    logic [3:0]  eff_addr;
    logic        blocked;
    logic        wr_en;
    logic [15:0] byte_we;

`ifdef GB_WAVE_DMG_QUIRK_EN
    localparam int CW = (ACCESS_WINDOW < 1) ? 1 : $clog2(ACCESS_WINDOW + 1);
    logic [CW-1:0] win_cnt;

    // Access window: reloaded by every fetch, then counts down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt <= '0;
        end else if (fetch) begin
            win_cnt <= CW'(ACCESS_WINDOW);
        end else if (win_cnt != '0) begin
            win_cnt <= win_cnt - 1'b1;
        end
    end
`endif

    // Fetch detection, CPU address redirection and access gating.
    always_comb begin
        fetch    = ch_on & ((ch_addr != prev_addr) | ~prev_on);
        eff_addr = ch_on ? ch_addr : cpu_addr;
`ifdef GB_WAVE_DMG_QUIRK_EN
        blocked  = ch_on & (win_cnt == '0);
`else
        blocked  = 1'b0;
`endif
        wr_en    = cpu_wr & ~blocked;
    end

    // One write-enable bit per byte of the pattern RAM.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_we
            assign byte_we[gi] = wr_en & (eff_addr == 4'(gi));
        end
    endgenerate

    // Pattern RAM storage; cleared entirely on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (byte_we[i]) begin
                    mem[i] <= cpu_wdata;
                end
            end
        end
    end

    // Previous channel address / on state used to detect fetches.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_addr <= 4'h0;
            prev_on   <= 1'b0;
        end else begin
            prev_addr <= ch_addr;
            prev_on   <= ch_on;
        end
    end

    // Sample buffer: tracks while the channel is off, loads only on fetch
    // while on. A same-cycle write lands in mem, the buffer gets the old byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ch_data <= 8'h00;
        end else if (!ch_on || fetch) begin
            ch_data <= mem[ch_addr];
        end
    end

    // Registered CPU read data; holds between reads, returns pre-write value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata <= 8'h00;
        end else if (cpu_rd) begin
            cpu_rdata <= blocked ? 8'hFF : mem[eff_addr];
        end
    end

endmodule

// File: tb/tb_gb_waveram.sv
// Directed bench for gb_waveram with a scoreboard queue of expected bytes.
// Build with +define+GB_WAVE_DMG_QUIRK_EN to exercise the DMG access window.
module tb_gb_waveram;

    logic       clk;
    logic       reset;
    logic [3:0] cpu_addr;
    logic       cpu_wr;
    logic       cpu_rd;
    logic [7:0] cpu_wdata;
    logic [7:0] cpu_rdata;
    logic       ch_on;
    logic [3:0] ch_addr;
    logic [7:0] ch_data;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    gb_waveram #(.ACCESS_WINDOW(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wr    (cpu_wr),
        .cpu_rd    (cpu_rd),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .ch_on     (ch_on),
        .ch_addr   (ch_addr),
        .ch_data   (ch_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_byte(input logic [7:0] e);
        exp_q.push_back(e);
    endtask

    task automatic check(input string tag, input logic [7:0] obs);
        logic [7:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%02h", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
        end
        $display("[%s] observed=%02h expected=%02h", tag, obs, e);
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_wr    = 1'b1;
        step();
        cpu_wr    = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a, input logic [7:0] e, input string tag);
        cpu_addr = a;
        cpu_rd   = 1'b1;
        expect_byte(e);
        step();
        cpu_rd   = 1'b0;
        check(tag, cpu_rdata);
    endtask

    task automatic check_ch(input logic [7:0] e, input string tag);
        expect_byte(e);
        check(tag, ch_data);
    endtask

    initial begin
        reset     = 1'b0;
        cpu_addr  = 4'h0;
        cpu_wr    = 1'b0;
        cpu_rd    = 1'b0;
        cpu_wdata = 8'h00;
        ch_on     = 1'b0;
        ch_addr   = 4'h0;
        repeat (3) step();

        // Reset state
        expect_byte(8'h00);
        check("rst_rdata", cpu_rdata);
        check_ch(8'h00, "rst_ch_data");
        reset = 1'b1;
        step();

        // 1: fill and read back with the channel off
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 8'(8'h11 * i));
        end
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i), 8'(8'h11 * i), $sformatf("t1_rd_%0d", i));
        end

        // 2: buffer tracks while off, including a fresh write
        ch_addr = 4'h5;
        step();
        check_ch(8'h55, "t2_track");
        do_write(4'h5, 8'hA5);
        step();
        check_ch(8'hA5, "t2_track_wr");

`ifdef GB_WAVE_DMG_QUIRK_EN
        // 5: access window after a fetch
        ch_addr = 4'h4;
        ch_on   = 1'b1;
        step();
        check_ch(8'h44, "t5_fetch");
        do_read(4'h0, 8'h44, "t5_rd_in_window");
        step();
        step();
        do_read(4'h0, 8'hFF, "t5_rd_closed");
        do_write(4'h0, 8'h66);
        ch_on = 1'b0;
        do_read(4'h4, 8'h44, "t5_wr_dropped");
`else
        // 3: redirection of CPU accesses to ch_addr while on
        ch_on   = 1'b1;
        ch_addr = 4'h3;
        step();
        check_ch(8'h33, "t3_fetch");
        do_write(4'h9, 8'h77);
        check_ch(8'h33, "t3_hold");
        do_read(4'h0, 8'h77, "t3_rd_redirect");
        ch_on = 1'b0;
        do_read(4'h9, 8'h99, "t3_mem9_kept");
        do_read(4'h3, 8'h77, "t3_mem3_new");

        // 4: address stepping with wrap, hold between changes
        ch_addr = 4'hE;
        ch_on   = 1'b1;
        step();
        check_ch(8'hEE, "t4_E");
        step();
        step();
        check_ch(8'hEE, "t4_E_hold");
        do_write(4'h0, 8'h5A);
        check_ch(8'hEE, "t4_E_hold_wr");
        ch_addr = 4'hF;
        step();
        check_ch(8'hFF, "t4_F");
        ch_addr = 4'h0;
        step();
        check_ch(8'h00, "t4_wrap_0");
        step();
        check_ch(8'h00, "t4_0_hold");
        ch_addr = 4'hE;
        step();
        check_ch(8'h5A, "t4_E_new");

        // Write and fetch to the same byte in the same cycle
        ch_addr   = 4'h1;
        cpu_wdata = 8'hC3;
        cpu_wr    = 1'b1;
        step();
        cpu_wr    = 1'b0;
        check_ch(8'h11, "coll_old");
        ch_addr = 4'h2;
        step();
        check_ch(8'h22, "coll_other");
        ch_addr = 4'h1;
        step();
        check_ch(8'hC3, "coll_new");
        ch_on = 1'b0;
`endif

        // Read and write together: read returns the pre-write value
        cpu_addr  = 4'h7;
        cpu_wdata = 8'h3C;
        cpu_rd    = 1'b1;
        cpu_wr    = 1'b1;
        expect_byte(8'h77);
        step();
        cpu_rd = 1'b0;
        cpu_wr = 1'b0;
        check("rdwr_old", cpu_rdata);
        do_read(4'h7, 8'h3C, "rdwr_new");

        // 6: reset mid-write
        do_write(4'h2, 8'h12);
        ch_addr = 4'h2;
        step();
        step();
        check_ch(8'h12, "t6_pre_ch");
        do_read(4'h2, 8'h12, "t6_pre_rd");
        cpu_addr  = 4'h2;
        cpu_wdata = 8'h99;
        cpu_wr    = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        expect_byte(8'h00);
        check("t6_rst_rdata", cpu_rdata);
        check_ch(8'h00, "t6_rst_ch");
        step();
        cpu_wr = 1'b0;
        reset  = 1'b1;
        step();
        do_read(4'h2, 8'h00, "t6_mem2_cleared");
        do_read(4'h3, 8'h00, "t6_mem3_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
